// File: rtl/mdu_sched.sv
// Multiply/divide sequencer: owns architectural HI/LO, computes the 64-bit
// result when the op is accepted, holds it for a fixed latency and then
// commits it. It also raises the ID-stage stall request.
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic        use_hilo_id,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;   // low for divide-by-zero: commit nothing
    logic               done_q, done_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               is_md;
    logic               is_valid;
    logic               accept;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_signed;
    logic [31:0]        num, den, den_safe, q_mag, r_mag, quot, rem;

    assign busy      = (state_q == RUN);
    assign is_md     = (op >= OP_MULT) && (op <= OP_DIVU);
    assign is_valid  = (op != 3'd0) && (op != 3'd7);
    assign accept    = start && !busy && !cancel && is_valid;
    assign stall_req = use_hilo_id && (busy || (start && is_md && !cancel));
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Datapath: products and sign-magnitude division of the current operands.
    always_comb begin
        prod_s     = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
        prod_u     = {32'd0, src_a} * {32'd0, src_b};
        div_signed = (op == OP_DIV);
        num        = (div_signed && src_a[31]) ? -src_a : src_a;
        den        = (div_signed && src_b[31]) ? -src_b : src_b;
        // Divisor of zero is replaced so the divider never sees it; the
        // result is discarded anyway via pend_wr.
        den_safe   = (den == 32'd0) ? 32'd1 : den;
        q_mag      = num / den_safe;
        r_mag      = num % den_safe;
        quot       = (div_signed && (src_a[31] ^ src_b[31])) ? -q_mag : q_mag;
        rem        = (div_signed && src_a[31]) ? -r_mag : r_mag;
    end

    // Next-state logic: accept in IDLE, count down in RUN, commit on 1->0.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            pend_wr_d = (src_b != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the pending result is reset too, so a reset mid-operation
        // cannot leave stale data that a later commit path might expose.
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: hand-computed HI/LO results, busy length,
// done pulse, stall_req and reset/cancel behaviour.
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        use_hilo_id;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .cancel      (cancel),
        .use_hilo_id (use_hilo_id),
        .busy        (busy),
        .stall_req   (stall_req),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // The hazard logic must never present a start while the unit is busy.
    always @(negedge clk) begin
        if (!reset && start && busy)
            check("start_while_busy", 1'b1, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div op for a single cycle and follow it to commit.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] eh,
                          input logic [31:0] el, input int cancel_at);
        logic [31:0] old_hi, old_lo;
        int cyc;
        old_hi = hi;
        old_lo = lo;
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        check({tag, "_stall_accept"}, stall_req, use_hilo_id);
        tick();
        start = 1'b0; op = 3'd0;
        check({tag, "_busy_T0"}, busy, 1'b1);
        cyc = 0;
        while (busy && cyc < 64) begin
            check({tag, "_stall_run"}, stall_req, use_hilo_id);
            check({tag, "_hold"}, {hi, lo}, {old_hi, old_lo});
            check({tag, "_no_done"}, done, 1'b0);
            cancel = (cyc + 1 == cancel_at);
            tick();
            cyc++;
        end
        cancel = 1'b0;
        check({tag, "_busy_len"}, 64'(cyc), 64'(n));
        check({tag, "_stall_off"}, stall_req, 1'b0);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_done"}, done, 1'b1);
        tick();
        check({tag, "_done_clr"}, done, 1'b0);
    endtask

    // Single-cycle mthi/mtlo write.
    task automatic move(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1; op = o; src_a = a; src_b = 32'hDEAD_BEEF;
        #1;
        check({tag, "_stall"}, stall_req, 1'b0);
        tick();
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        cancel = 1'b0; use_hilo_id = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_stall", stall_req, 1'b0);

        // mult -3 * 5 = -15
        run_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);

        // divu 100/7, then div -7/2
        run_op("divu", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 0);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);

        // mthi/mtlo back-to-back, with an mf* in ID that must not stall
        use_hilo_id = 1'b1;
        move("mthi", 3'd5, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFD);
        move("mtlo", 3'd6, 32'hCAFE_BABE, 32'h1234_5678, 32'hCAFE_BABE);
        start = 1'b0; op = 3'd0;

        // multu with mflo waiting in ID: stall spans acceptance through busy
        run_op("multu_stall", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'hFFFF_FFFE, 32'h0000_0001, 0);

        // div cancelled in its acceptance cycle: nothing happens
        start = 1'b1; op = 3'd3; src_a = 32'd50; src_b = 32'd5; cancel = 1'b1;
        #1;
        check("cancel_stall", stall_req, 1'b0);
        tick();
        start = 1'b0; op = 3'd0; cancel = 1'b0;
        check("cancel_busy", busy, 1'b0);
        check("cancel_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        tick();
        check("cancel_done", done, 1'b0);
        use_hilo_id = 1'b0;

        // cancel pulsed mid-RUN does not stop the operation
        run_op("multu_cancel", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE, 2);

        // reserved/none ops are ignored
        start = 1'b1; op = 3'd7; src_a = 32'd9; src_b = 32'd9;
        tick();
        check("op7_busy", busy, 1'b0);
        op = 3'd0;
        tick();
        start = 1'b0;
        check("op0_busy", busy, 1'b0);
        check("op_ign_hilo", {hi, lo}, {32'd1, 32'hFFFF_FFFE});

        // signed overflow case and divide by zero
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 0);
        run_op("div_zero", 3'd3, 32'd5, 32'd0, 10, 32'd0, 32'h8000_0000, 0);
        run_op("divu_zero", 3'd4, 32'd5, 32'd0, 10, 32'd0, 32'h8000_0000, 0);

        // reset on cycle 3 of a div: no commit, HI/LO cleared, no done
        move("pre_rst", 3'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h8000_0000);
        start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd3;
        tick();
        start = 1'b0; op = 3'd0;
        tick(); tick();
        check("mid_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", busy, 1'b0);
        check("mrst_hilo", {hi, lo}, 64'd0);
        check("mrst_done", done, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("mrst_no_commit", {hi, lo, busy, done}, 66'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
